inst_buffer: RTL

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular queue that accepts up
// to N compacted fetch packets per cycle and presents the oldest N to decode.

`ifndef N
`define N 2
`endif

`ifndef NOP
`define NOP 32'h00000013
`endif

package inst_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] NPC;
    logic [31:0] PC;
    logic        predict_taken;
    logic [31:0] predict_target;
  } IF_ID_PACKET;
endpackage

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int N     = `N,
  parameter int DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  IF_ID_PACKET [N-1:0]            if_id_packet,
  input  logic [$clog2(N+1)-1:0]         dispatch_num,
  output logic                           fetch_stall,
  output IF_ID_PACKET [N-1:0]            ib_out_packet,
  output logic [$clog2(DEPTH+1)-1:0]     avail_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 * N || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("inst_buffer: DEPTH must be a power of two and at least 2*N");
  end

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  IF_ID_PACKET   mem [DEPTH];

  logic          enq_en;
  logic [CW-1:0] enq_cnt;
  logic [CW-1:0] deq_cnt;
  logic [PW-1:0] slot_off [N];

  // Stall uses only the registered occupancy so fetch never sees a path from decode.
  assign fetch_stall = (CW'(DEPTH) - count) < CW'(N);
  assign enq_en      = !fetch_stall && !squash;
  assign avail_count = count;

  // Each valid slot lands at tail plus the number of valid slots below it.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < N; i++) begin
      slot_off[i] = enq_cnt[PW-1:0];
      if (enq_en && if_id_packet[i].valid) begin
        enq_cnt = enq_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    deq_cnt = CW'(dispatch_num);
    if (deq_cnt > count) begin
      deq_cnt = count;
    end
    if (deq_cnt > CW'(N)) begin
      deq_cnt = CW'(N);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_cnt[PW-1:0];
      tail  <= tail + enq_cnt[PW-1:0];
      count <= count + enq_cnt - deq_cnt;
    end
  end

  // Storage is never cleared; entries outside head..head+count are simply ignored.
  always_ff @(posedge clock) begin
    if (enq_en) begin
      for (int i = 0; i < N; i++) begin
        if (if_id_packet[i].valid) begin
          mem[tail + slot_off[i]] <= if_id_packet[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < count) begin
        ib_out_packet[i]       = mem[head + PW'(i)];
        ib_out_packet[i].valid = 1'b1;
      end else begin
        ib_out_packet[i]      = '0;
        ib_out_packet[i].inst = `NOP;
      end
    end
  end

endmodule
